klein_key_sched: RTL

KLEIN_KEY_SCHED -- requirements
Module: klein_key_sched

---
 rtl/klein_key_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/klein_key_sched.sv
// KLEIN key schedule: emits ROUNDS+1 round keys (one per cycle at most), each held until rk_ready.
// KLEIN_KS_STORE_EN adds a round-key store with 1-cycle readback on rd_addr; otherwise rd_data is 0.
module klein_key_sched #(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [63:0]      rk_out,
  output logic [4:0]       rk_idx,
  output logic             busy,
  output logic             done,
  output logic [KEY_W-1:0] final_key,
  input  logic [4:0]       rd_addr,
  output logic [63:0]      rd_data
);

  localparam int HW = KEY_W / 2;
  localparam logic [4:0] LAST_IDX = 5'(ROUNDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h7;
      4'h1: y = 4'h4;
      4'h2: y = 4'hA;
      4'h3: y = 4'h9;
      4'h4: y = 4'h1;
      4'h5: y = 4'hF;
      4'h6: y = 4'hB;
      4'h7: y = 4'h0;
      4'h8: y = 4'hC;
      4'h9: y = 4'h3;
      4'hA: y = 4'h2;
      4'hB: y = 4'h6;
      4'hC: y = 4'h8;
      4'hD: y = 4'hE;
      4'hE: y = 4'hD;
      default: y = 4'h5;
    endcase
    return y;
  endfunction

  function automatic logic [7:0] sbox8(input logic [7:0] x);
    return {sbox(x[7:4]), sbox(x[3:0])};
  endfunction

  // Byte k of a half sits at [HW-1-8k -: 8]; byte 0 is the most significant.
  function automatic logic [KEY_W-1:0] ks_update(input logic [KEY_W-1:0] s, input logic [7:0] rc);
    logic [HW-1:0] a, b, ar, br, na, nb;
    a  = s[KEY_W-1 -: HW];
    b  = s[HW-1:0];
    ar = {a[HW-9:0], a[HW-1 -: 8]};
    br = {b[HW-9:0], b[HW-1 -: 8]};
    na = br;
    nb = ar ^ br;
    na[HW-17 -: 8] = na[HW-17 -: 8] ^ rc;
    nb[HW-9 -: 8]  = sbox8(nb[HW-9 -: 8]);
    nb[HW-17 -: 8] = sbox8(nb[HW-17 -: 8]);
    return {na, nb};
  endfunction

  logic [1:0]       fsm_q, fsm_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [7:0]       rc_q, rc_d;
  logic [4:0]       idx_q, idx_d;
  logic [KEY_W-1:0] fk_q, fk_d;
  logic             accept;

  assign accept = (fsm_q == S_EMIT) && rk_ready;

  always_comb begin
    fsm_d = fsm_q;
    key_d = key_q;
    rc_d  = rc_q;
    idx_d = idx_q;
    fk_d  = fk_q;
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          key_d = key_in;
          rc_d  = 8'd1;
          idx_d = 5'd0;
          fsm_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            fk_d  = key_q;
            fsm_d = S_FIN;
          end else begin
            key_d = ks_update(key_q, rc_q);
            rc_d  = rc_q + 8'd1;
            idx_d = idx_q + 5'd1;
          end
        end
      end
      S_FIN:   fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= S_IDLE;
      key_q <= '0;
      rc_q  <= '0;
      idx_q <= '0;
      fk_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      key_q <= key_d;
      rc_q  <= rc_d;
      idx_q <= idx_d;
      fk_q  <= fk_d;
    end
  end

  assign rk_valid  = (fsm_q == S_EMIT);
  assign busy      = (fsm_q != S_IDLE);
  assign done      = (fsm_q == S_FIN);
  assign rk_out    = key_q[KEY_W-1 -: 64];
  assign rk_idx    = idx_q;
  assign final_key = fk_q;

`ifdef KLEIN_KS_STORE_EN
  logic [63:0] store_q [0:ROUNDS];
  logic [63:0] store_d [0:ROUNDS];
  logic [63:0] rd_q, rd_d;

  always_comb begin
    store_d = store_q;
    if (accept) store_d[idx_q] = rk_out;
    rd_d = (rd_addr <= LAST_IDX) ? store_q[rd_addr] : 64'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= ROUNDS; k++) store_q[k] <= '0;
      rd_q <= '0;
    end else begin
      store_q <= store_d;
      rd_q    <= rd_d;
    end
  end

  assign rd_data = rd_q;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = 64'd0;
`endif

endmodule
